// File: rtl/fill_rect_clip_engine.sv
// fill_rect_clip_engine: collects a byte-serial fill command, clips it to the screen and
// emits packed, byte-masked framebuffer word writes one per arbiter handshake.
module fill_rect_clip_engine #(
    parameter int   DATA_W    = 32,
    parameter int   PIX_W     = 8,
    parameter int   ADDR_W    = 16,
    parameter int   SCREEN_W  = 160,
    parameter int   SCREEN_H  = 120,
    parameter int   BASE_ADDR = 0,
    parameter logic OP_WRITE  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [7:0]          cmd_in_data,
    input  logic                cmd_in_rts,
    output logic                cmd_out_rtr,
    output logic [DATA_W-1:0]   arb_out_data,
    output logic [ADDR_W-1:0]   arb_out_addr,
    output logic [DATA_W/8-1:0] arb_out_wben,
    output logic                arb_out_op,
    output logic                arb_out_rts,
    input  logic                arb_in_rtr,
    output logic                busy,
    output logic                cmd_dropped
);
    localparam int PPW = DATA_W / PIX_W;
    localparam int NB  = DATA_W / 8;
    localparam int BPP = PIX_W / 8;
    localparam int CB  = 8 + BPP;
    localparam int CW  = $clog2(CB);
    localparam int WPR = SCREEN_W / PPW;

    typedef enum logic [1:0] {COLLECT, CLIP, EMIT} state_t;

    state_t           state, state_n;
    logic [CB*8-1:0]  cmd;
    logic [CW-1:0]    cnt;
    logic             live;
    logic [15:0]      xe, ye, row, col;
    logic [15:0]      x, y, w, h;
    logic [PIX_W-1:0] color;
    logic [16:0]      xe_raw, ye_raw;
    logic             drop, byte_xfer, arb_xfer, last_col, last_word, emit;

    // Command bytes shift in from the top, so byte 0 ends up in the low bits.
    assign x     = cmd[15:0];
    assign y     = cmd[31:16];
    assign w     = cmd[47:32];
    assign h     = cmd[63:48];
    assign color = cmd[64 +: PIX_W];

    assign xe_raw    = 17'(x) + 17'(w) - 17'd1;
    assign ye_raw    = 17'(y) + 17'(h) - 17'd1;
    assign drop      = (w == 16'd0) || (h == 16'd0) || (32'(x) >= 32'(SCREEN_W)) || (32'(y) >= 32'(SCREEN_H));
    assign byte_xfer = cmd_in_rts && cmd_out_rtr;
    assign arb_xfer  = arb_out_rts && arb_in_rtr;
    assign last_col  = col == 16'(32'(xe) / PPW);
    assign last_word = last_col && (row == ye);
    assign emit      = state == EMIT;
    assign busy      = (state != COLLECT) || (cnt != '0);
    assign arb_out_op = arb_out_rts ? OP_WRITE : 1'b0;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) state <= COLLECT;
        else      state <= state_n;
    end

    always_comb begin
        state_n     = state;
        cmd_out_rtr = 1'b0;
        arb_out_rts = 1'b0;
        cmd_dropped = 1'b0;
        case (state)
            COLLECT: begin
                cmd_out_rtr = live;
                if (byte_xfer && cnt == CW'(CB - 1)) state_n = CLIP;
            end
            CLIP: begin
                cmd_dropped = drop;
                state_n     = drop ? COLLECT : EMIT;
            end
            EMIT: begin
                arb_out_rts = 1'b1;
                if (arb_xfer && last_word) state_n = COLLECT;
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            live <= 1'b0;
            cmd  <= '0;
            cnt  <= '0;
            xe   <= '0;
            ye   <= '0;
            row  <= '0;
            col  <= '0;
        end else begin
            live <= 1'b1;
            if (byte_xfer) begin
                cmd <= {cmd_in_data, cmd[CB*8-1:8]};
                cnt <= (cnt == CW'(CB - 1)) ? '0 : cnt + 1'b1;
            end
            if (state == CLIP) begin
                xe  <= (xe_raw > 17'(SCREEN_W - 1)) ? 16'(SCREEN_W - 1) : xe_raw[15:0];
                ye  <= (ye_raw > 17'(SCREEN_H - 1)) ? 16'(SCREEN_H - 1) : ye_raw[15:0];
                row <= y;
                col <= 16'(32'(x) / PPW);
            end
            if (arb_xfer) begin
                row <= last_col ? row + 16'd1 : row;
                col <= last_col ? 16'(32'(x) / PPW) : col + 16'd1;
            end
        end
    end

    // Every lane carries the color; only lanes whose pixel lies in [x, xe] are enabled.
    always_comb begin
        for (int b = 0; b < NB; b++)
            arb_out_wben[b] = emit && (32'(col) * PPW + b / BPP >= 32'(x))
                                   && (32'(col) * PPW + b / BPP <= 32'(xe));
    end

    assign arb_out_data = emit ? {PPW{color}} : '0;
    assign arb_out_addr = emit ? ADDR_W'(32'(BASE_ADDR) + 32'(row) * WPR + 32'(col)) : '0;
endmodule

// File: tb/tb_fill_rect_clip_engine.sv
// tb_fill_rect_clip_engine: table-driven and hand-sequenced checks of the fill engine,
// with a write scoreboard for the default 8-bit instance and a second 16-bit-pixel instance.
module tb_fill_rect_clip_engine;
    typedef struct {
        logic [15:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [15:0] x, y, w, h;
        logic [7:0]  c;
        int          nw;
        int          nd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [7:0]  cmd_in_data = '0;
    logic        cmd_in_rts = 1'b0;
    logic        cmd_out_rtr;
    logic [31:0] arb_out_data;
    logic [15:0] arb_out_addr;
    logic [3:0]  arb_out_wben;
    logic        arb_out_op, arb_out_rts;
    logic        arb_in_rtr = 1'b1;
    logic        busy, cmd_dropped;

    logic [7:0]  c16_data = '0;
    logic        c16_rts = 1'b0;
    logic        c16_rtr, a16_op, a16_rts, busy16, drop16;
    logic [31:0] a16_data;
    logic [15:0] a16_addr;
    logic [3:0]  a16_wben;
    logic        one = 1'b1;

    int  total = 0, passed = 0;
    int  writes = 0, drops = 0, w16 = 0;
    bit  stall = 0;
    int  scnt = 0;
    bit  prev_stall = 0;
    wr_t held;
    wr_t exp_q[$];
    wr_t q16[$];

    fill_rect_clip_engine dut (
        .clk(clk), .rst_(rst_), .cmd_in_data(cmd_in_data), .cmd_in_rts(cmd_in_rts),
        .cmd_out_rtr(cmd_out_rtr), .arb_out_data(arb_out_data), .arb_out_addr(arb_out_addr),
        .arb_out_wben(arb_out_wben), .arb_out_op(arb_out_op), .arb_out_rts(arb_out_rts),
        .arb_in_rtr(arb_in_rtr), .busy(busy), .cmd_dropped(cmd_dropped)
    );

    fill_rect_clip_engine #(.PIX_W(16)) dut16 (
        .clk(clk), .rst_(rst_), .cmd_in_data(c16_data), .cmd_in_rts(c16_rts),
        .cmd_out_rtr(c16_rtr), .arb_out_data(a16_data), .arb_out_addr(a16_addr),
        .arb_out_wben(a16_wben), .arb_out_op(a16_op), .arb_out_rts(a16_rts),
        .arb_in_rtr(one), .busy(busy16), .cmd_dropped(drop16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Arbiter model: in stall mode hold rtr low for 5 cycles of every presented word.
    always @(posedge clk) begin
        #2;
        if (stall && arb_out_rts && scnt < 5) begin
            arb_in_rtr = 1'b0;
            scnt++;
        end else begin
            arb_in_rtr = 1'b1;
            scnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_) prev_stall = 0;
        else begin
            if (prev_stall)
                chk("stall_hold", {arb_out_addr, arb_out_wben, arb_out_data}, {held.a, held.be, held.d});
            if (arb_out_rts && arb_in_rtr) begin
                wr_t e;
                writes++;
                if (exp_q.size() == 0) chk("unexpected_write", {arb_out_addr, arb_out_wben}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", arb_out_addr, e.a);
                    chk("wr_wben", arb_out_wben, e.be);
                    chk("wr_data", arb_out_data, e.d);
                    chk("wr_op", arb_out_op, 1);
                end
            end
            if (cmd_dropped) drops++;
            prev_stall = arb_out_rts && !arb_in_rtr;
            held = '{arb_out_addr, arb_out_wben, arb_out_data};
        end
    end

    always @(negedge clk) begin
        if (!rst_ && a16_rts) begin
            wr_t e;
            w16++;
            if (q16.size() == 0) chk("p16_unexpected", a16_addr, 0);
            else begin
                e = q16.pop_front();
                chk("p16_addr", a16_addr, e.a);
                chk("p16_wben", a16_wben, e.be);
                chk("p16_data", a16_data, e.d);
            end
        end
    end

    task automatic push_model(input int x, y, w, h, input logic [7:0] c);
        int xe, ye;
        wr_t e;
        if (w == 0 || h == 0 || x >= 160 || y >= 120) return;
        xe = (x + w - 1 > 159) ? 159 : x + w - 1;
        ye = (y + h - 1 > 119) ? 119 : y + h - 1;
        for (int r = y; r <= ye; r++)
            for (int k = x / 4; k <= xe / 4; k++) begin
                e.a  = 16'(r * 40 + k);
                e.d  = {4{c}};
                e.be = '0;
                for (int p = 0; p < 4; p++)
                    if (k * 4 + p >= x && k * 4 + p <= xe) e.be[p] = 1'b1;
                exp_q.push_back(e);
            end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        cmd_in_data = b;
        cmd_in_rts  = 1'b1;
        while (!cmd_out_rtr && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("byte_timeout", 0, 1);
        @(negedge clk);
        cmd_in_rts = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] x, y, w, h, input logic [7:0] c);
        logic [71:0] v = {c, h, w, y, x};
        for (int i = 0; i < 9; i++) send_byte(v[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 5000);
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic push_t1();
        exp_q.push_back('{16'd40, 4'b1100, 32'hA5A5A5A5});
        exp_q.push_back('{16'd41, 4'b0011, 32'hA5A5A5A5});
        exp_q.push_back('{16'd80, 4'b1100, 32'hA5A5A5A5});
        exp_q.push_back('{16'd81, 4'b0011, 32'hA5A5A5A5});
    endtask

    initial begin
        vec_t tbl[9];
        int w0, d0, t;
        bit bad;
        logic [79:0] v16;
        tbl = '{
            '{16'd2,   16'd1,   16'd4,     16'd2,     8'hA5, 4,    0},
            '{16'd158, 16'd119, 16'd10,    16'd10,    8'h3C, 1,    0},
            '{16'd0,   16'd0,   16'hFFFF,  16'd1,     8'h11, 40,   0},
            '{16'd5,   16'd5,   16'd0,     16'd3,     8'h22, 0,    1},
            '{16'd160, 16'd0,   16'd1,     16'd1,     8'h33, 0,    1},
            '{16'd0,   16'd120, 16'd1,     16'd1,     8'h44, 0,    1},
            '{16'd3,   16'd10,  16'd1,     16'd1,     8'h77, 1,    0},
            '{16'd1,   16'd2,   16'd7,     16'd3,     8'h5A, 6,    0},
            '{16'd100, 16'd50,  16'hFFFF,  16'hFFFF,  8'hC3, 1050, 0}
        };

        repeat (3) @(negedge clk);
        chk("rst_rtr", cmd_out_rtr, 0);
        chk("rst_rts", arb_out_rts, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus", {arb_out_addr, arb_out_wben, arb_out_data, arb_out_op}, 0);
        rst_ = 1'b0;
        @(negedge clk);
        chk("rel_rtr", cmd_out_rtr, 1);

        // Spec example 1 with exact values and CLIP/EMIT latency.
        push_t1();
        w0 = writes;
        send_cmd(16'd2, 16'd1, 16'd4, 16'd2, 8'hA5);
        chk("t1_clip_rts", arb_out_rts, 0);
        chk("t1_clip_rtr", cmd_out_rtr, 0);
        @(negedge clk);
        chk("t1_emit_rts", arb_out_rts, 1);
        wait_idle();
        chk("t1_writes", writes - w0, 4);
        chk("t1_done_rtr", cmd_out_rtr, 1);

        exp_q.push_back('{16'd4799, 4'b1100, 32'h3C3C3C3C});
        w0 = writes;
        send_cmd(16'd158, 16'd119, 16'd10, 16'd10, 8'h3C);
        wait_idle();
        chk("t2_writes", writes - w0, 1);

        // Drops: pulse during the CLIP cycle, ready again one cycle later.
        for (int i = 0; i < 2; i++) begin
            d0 = drops;
            if (i == 0) send_cmd(16'd0, 16'd0, 16'd0, 16'd1, 8'h01);
            else        send_cmd(16'd160, 16'd0, 16'd1, 16'd1, 8'h01);
            chk("drop_pulse", cmd_dropped, 1);
            chk("drop_rtr0", cmd_out_rtr, 0);
            @(negedge clk);
            chk("drop_pulse_end", cmd_dropped, 0);
            chk("drop_rtr1", cmd_out_rtr, 1);
            chk("drop_rts", arb_out_rts, 0);
            chk("drop_count", drops - d0, 1);
        end

        foreach (tbl[i]) begin
            w0 = writes;
            d0 = drops;
            push_model(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c);
            send_cmd(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c);
            wait_idle();
            chk($sformatf("vec%0d_writes", i), writes - w0, tbl[i].nw);
            chk($sformatf("vec%0d_drops", i), drops - d0, tbl[i].nd);
            chk($sformatf("vec%0d_q", i), exp_q.size(), 0);
        end

        // Backpressure, with the next command's first byte offered during EMIT.
        stall = 1;
        push_t1();
        w0 = writes;
        send_cmd(16'd2, 16'd1, 16'd4, 16'd2, 8'hA5);
        cmd_in_data = 8'd158;
        cmd_in_rts  = 1'b1;
        t = 0;
        bad = 0;
        while (busy && t < 500) begin
            if (cmd_out_rtr) bad = 1;
            @(negedge clk);
            t++;
        end
        chk("bp_holdoff", bad, 0);
        chk("bp_busy", busy, 0);
        chk("bp_writes", writes - w0, 4);
        stall = 0;
        exp_q.push_back('{16'd4799, 4'b1100, 32'h3C3C3C3C});
        w0 = writes;
        send_cmd(16'd158, 16'd119, 16'd10, 16'd10, 8'h3C);
        wait_idle();
        chk("bp_next_writes", writes - w0, 1);

        // Reset after the second write is accepted.
        push_t1();
        w0 = writes;
        send_cmd(16'd2, 16'd1, 16'd4, 16'd2, 8'hA5);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (writes - w0 < 2 && t < 100);
        chk("rst_wait", writes - w0, 2);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        #1;
        chk("arst_rts", arb_out_rts, 0);
        chk("arst_bus", {arb_out_addr, arb_out_wben, arb_out_data, arb_out_op}, 0);
        chk("arst_busy_rtr", {busy, cmd_out_rtr, cmd_dropped}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        chk("arst_rel_rtr", cmd_out_rtr, 1);
        for (int i = 0; i < 3; i++) send_byte(8'hEE);
        chk("partial_busy", busy, 1);
        rst_ = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        chk("partial_cleared", busy, 0);
        push_t1();
        w0 = writes;
        send_cmd(16'd2, 16'd1, 16'd4, 16'd2, 8'hA5);
        wait_idle();
        chk("post_rst_writes", writes - w0, 4);
        chk("post_rst_q", exp_q.size(), 0);

        // 16-bit pixels: two pixels straddling a word boundary.
        q16.push_back('{16'd0, 4'b1100, 32'hBEEFBEEF});
        q16.push_back('{16'd1, 4'b0011, 32'hBEEFBEEF});
        chk("p16_rtr", c16_rtr, 1);
        v16 = {16'hBEEF, 16'd1, 16'd2, 16'd0, 16'd1};
        for (int i = 0; i < 10; i++) begin
            c16_data = v16[8*i +: 8];
            c16_rts  = 1'b1;
            @(negedge clk);
        end
        c16_rts = 1'b0;
        repeat (8) @(negedge clk);
        chk("p16_writes", w16, 2);
        chk("p16_idle", busy16, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
